// File: rtl/insn_encoder_pkg.sv
// Shared types and RV32I encoding constants for the instruction encoder.
package insn_encoder_pkg;

  localparam int unsigned INSN_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 13;
  localparam int unsigned OPC_W  = 7;

  typedef enum logic [2:0] {
    ENC_LW  = 3'd0,
    ENC_SW  = 3'd1,
    ENC_AND = 3'd2,
    ENC_OR  = 3'd3,
    ENC_ADD = 3'd4,
    ENC_SUB = 3'd5,
    ENC_BEQ = 3'd6,
    ENC_BLT = 3'd7
  } enc_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } enc_state_t;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LW_SW   = 3'b010;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BLT     = 3'b100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef logic [REG_W-1:0] reg_addr_t;

  typedef struct packed {
    enc_op_t          op;
    reg_addr_t        rs1;
    reg_addr_t        rs2;
    reg_addr_t        rd;
    logic [IMM_W-1:0] imm;
  } enc_req_t;

  function automatic logic [INSN_W-1:0] r_type(input logic [6:0] f7, input reg_addr_t rs2,
                                               input reg_addr_t rs1, input logic [2:0] f3,
                                               input reg_addr_t rd);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction

endpackage

// File: rtl/insn_encoder_if.sv
// Request channel and instruction-memory write channel of the encoder.
interface insn_encoder_if
  import insn_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);
  logic                req_valid;
  logic                req_ready;
  enc_op_t             req_op;
  reg_addr_t           req_rs1;
  reg_addr_t           req_rs2;
  reg_addr_t           req_rd;
  logic [IMM_W-1:0]    req_imm;
  logic                imem_we;
  logic                imem_ready;
  logic [ADDR_W-1:0]   imem_addr;
  logic [INSN_W-1:0]   imem_wdata;

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_rd, req_imm, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_rd, req_imm, imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/insn_enc_fifo.sv
// Two-entry FIFO holding {addr,data} write entries; head is read directly from storage.
module insn_enc_fifo #(
  parameter int unsigned W = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
endmodule

// File: rtl/insn_encoder.sv
// Encodes symbolic requests into RV32I words and streams them into imem from a base address.
// Optional INSN_ENCODER_CHECKSUM_EN adds an XOR checksum of every word written.
module insn_encoder
  import insn_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  insn_encoder_if.slave     bus,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef INSN_ENCODER_CHECKSUM_EN
  ,
  output logic [INSN_W-1:0] checksum
`endif
);
  localparam int unsigned ENTRY_W = ADDR_W + INSN_W;

  enc_state_t        state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              err_q, err_d;
  logic              busy_q, done_q;

  enc_req_t           req;
  logic [INSN_W-1:0]  enc_word;
  logic               enc_reject;
  logic               xfer;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;

  always_comb begin
    req     = '0;
    req.op  = bus.req_op;
    req.rs1 = bus.req_rs1;
    req.rs2 = bus.req_rs2;
    req.rd  = bus.req_rd;
    req.imm = bus.req_imm;
  end

  // Encoder: each format pulls immediate bits only from its defined positions.
  always_comb begin
    enc_word   = '0;
    enc_reject = 1'b0;
    unique case (req.op)
      ENC_LW: begin
        enc_word   = {req.imm[11:0], req.rs1, F3_LW_SW, req.rd, OP_LOAD};
        enc_reject = req.imm[12] ^ req.imm[11];
      end
      ENC_SW: begin
        enc_word   = {req.imm[11:5], req.rs2, req.rs1, F3_LW_SW, req.imm[4:0], OP_STORE};
        enc_reject = req.imm[12] ^ req.imm[11];
      end
      ENC_AND: enc_word = r_type(F7_BASE, req.rs2, req.rs1, F3_AND, req.rd);
      ENC_OR:  enc_word = r_type(F7_BASE, req.rs2, req.rs1, F3_OR, req.rd);
      ENC_ADD: enc_word = r_type(F7_BASE, req.rs2, req.rs1, F3_ADD_SUB, req.rd);
      ENC_SUB: enc_word = r_type(F7_SUB, req.rs2, req.rs1, F3_ADD_SUB, req.rd);
      ENC_BEQ: begin
        enc_word   = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, F3_BEQ,
                      req.imm[4:1], req.imm[11], OP_BRANCH};
        enc_reject = req.imm[0];
      end
      ENC_BLT: begin
        enc_word   = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, F3_BLT,
                      req.imm[4:1], req.imm[11], OP_BRANCH};
        enc_reject = req.imm[0];
      end
    endcase
  end

  assign bus.req_ready = (state_q == S_RUN) && (remaining_q != '0) && !fifo_full;
  assign xfer          = bus.req_valid && bus.req_ready;
  assign push          = xfer && !enc_reject;
  assign pop           = !fifo_empty && bus.imem_ready;

  insn_enc_fifo #(.W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({wr_addr_q, enc_word}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.imem_we    = !fifo_empty;
  assign bus.imem_addr  = fifo_rdata[ENTRY_W-1:INSN_W];
  assign bus.imem_wdata = fifo_rdata[INSN_W-1:0];

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wr_addr_d   = wr_addr_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          remaining_d = length;
          wr_addr_d   = base_addr;
          err_d       = 1'b0;
        end
      end
      S_RUN: begin
        if (remaining_q == '0) begin
          state_d = S_DRAIN;
        end else if (xfer) begin
          remaining_d = remaining_q - LEN_W'(1);
          // Rejected requests are consumed but leave the write address untouched.
          if (enc_reject) err_d = 1'b1;
          else            wr_addr_d = wr_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (fifo_empty) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      wr_addr_q   <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wr_addr_q   <= wr_addr_d;
      err_q       <= err_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

`ifdef INSN_ENCODER_CHECKSUM_EN
  logic [INSN_W-1:0] checksum_q;

  // Cleared on an accepted start, accumulates every completed imem write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q ^ fifo_rdata[INSN_W-1:0];
    end
  end

  assign checksum = checksum_q;
`endif
endmodule

// File: tb/tb_insn_encoder.sv
// Directed, table-driven bench for insn_encoder with hand-computed RV32I encodings.
module tb_insn_encoder;
  import insn_encoder_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] length;
  logic       busy;
  logic       done;
  logic       err;
`ifdef INSN_ENCODER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  insn_encoder_if #(.ADDR_W(8)) bus ();

  insn_encoder #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef INSN_ENCODER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    enc_op_t     op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [12:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t tbl [8];
  wr_t  wr_q [$];
  wr_t  exp_q [$];
  int   checks = 0;
  int   failures = 0;

  always @(negedge clk) begin
    if (rst_n && bus.imem_we && bus.imem_ready)
      wr_q.push_back({bus.imem_addr, bus.imem_wdata});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic start_prog(input logic [7:0] b, input logic [7:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send(input enc_op_t op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [12:0] imm);
    int n;
    bus.req_op    = op;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_rd    = rd;
    bus.req_imm   = imm;
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.req_ready !== 1'b1) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (done !== 1'b1 && n < 60);
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_q[i].addr), 32'(exp_q[i].addr));
      chk($sformatf("%s_data%0d", tag, i), wr_q[i].data, exp_q[i].data);
    end
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic run_table(input int lo, input int hi, input logic [7:0] b, input string tag);
    int n;
    logic [31:0] xs;
    xs = '0;
    start_prog(b, 8'(hi - lo + 1));
    for (int i = lo; i <= hi; i++) begin
      send(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm);
      if (i == lo) begin
        chk({tag, "_lat_we"}, 32'(bus.imem_we), 32'd1);
        chk({tag, "_lat_addr"}, 32'(bus.imem_addr), 32'(b));
        chk({tag, "_lat_data"}, bus.imem_wdata, tbl[i].exp);
      end
      exp_q.push_back({8'(b + 8'(i - lo)), tbl[i].exp});
      xs = xs ^ tbl[i].exp;
    end
    wait_done(n);
    chk({tag, "_err"}, 32'(err), 32'd0);
`ifdef INSN_ENCODER_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, xs);
`endif
    check_writes(tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    logic saw_done;

    tbl[0] = '{ENC_ADD, 5'd1, 5'd2, 5'd3, 13'h0000, 32'h002081B3};
    tbl[1] = '{ENC_SUB, 5'd1, 5'd2, 5'd3, 13'h0000, 32'h402081B3};
    tbl[2] = '{ENC_AND, 5'd6, 5'd7, 5'd5, 13'h0000, 32'h007372B3};
    tbl[3] = '{ENC_OR,  5'd6, 5'd7, 5'd5, 13'h0000, 32'h007362B3};
    tbl[4] = '{ENC_LW,  5'd2, 5'd0, 5'd1, 13'h0008, 32'h00812083};
    tbl[5] = '{ENC_SW,  5'd2, 5'd1, 5'd0, 13'h1FFC, 32'hFE112E23};
    tbl[6] = '{ENC_BEQ, 5'd1, 5'd2, 5'd0, 13'h0008, 32'h00208463};
    tbl[7] = '{ENC_BLT, 5'd1, 5'd2, 5'd0, 13'h1FFC, 32'hFE20CEE3};

    rst_n          = 1'b0;
    start          = 1'b0;
    base_addr      = '0;
    length         = '0;
    bus.req_valid  = 1'b0;
    bus.req_op     = ENC_LW;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.req_rd     = '0;
    bus.req_imm    = '0;
    bus.imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // R-type program, then loads/stores/branches
    run_table(0, 3, 8'h10, "rtype");
    run_table(4, 7, 8'h18, "membr");

    // Back-pressure: two entries buffered while imem stalls, third waits
    bus.imem_ready = 1'b0;
    start_prog(8'h20, 8'd3);
    send(ENC_AND, 5'd6, 5'd7, 5'd5, 13'h0000);
    send(ENC_OR, 5'd6, 5'd7, 5'd5, 13'h0000);
    chk("stall_ready_low", 32'(bus.req_ready), 32'd0);
    fork
      send(ENC_LW, 5'd2, 5'd0, 5'd1, 13'h0008);
      begin
        for (int c = 0; c < 5; c++) begin
          chk("stall_we", 32'(bus.imem_we), 32'd1);
          chk("stall_addr", 32'(bus.imem_addr), 32'h20);
          chk("stall_data", bus.imem_wdata, 32'h007372B3);
          chk("stall_ready", 32'(bus.req_ready), 32'd0);
          @(posedge clk); #1;
        end
        bus.imem_ready = 1'b1;
      end
    join
    wait_done(n);
    exp_q.push_back({8'h20, 32'h007372B3});
    exp_q.push_back({8'h21, 32'h007362B3});
    exp_q.push_back({8'h22, 32'h00812083});
    check_writes("stall");
    @(posedge clk); #1;

    // Rejections: consumed, not written, address not advanced
    start_prog(8'h30, 8'd3);
    send(ENC_LW, 5'd2, 5'd0, 5'd1, 13'h0800);
    send(ENC_BEQ, 5'd1, 5'd2, 5'd0, 13'h0003);
    chk("rej_err_early", 32'(err), 32'd1);
    send(ENC_ADD, 5'd1, 5'd2, 5'd3, 13'h0000);
    wait_done(n);
    chk("rej_err", 32'(err), 32'd1);
    exp_q.push_back({8'h30, 32'h002081B3});
    check_writes("rej");
    @(posedge clk); #1;

    // Address wrap; err cleared by start
    start_prog(8'hFF, 8'd2);
    chk("wrap_err_cleared", 32'(err), 32'd0);
    send(ENC_ADD, 5'd1, 5'd2, 5'd3, 13'h0000);
    send(ENC_SUB, 5'd1, 5'd2, 5'd3, 13'h0000);
    wait_done(n);
    exp_q.push_back({8'hFF, 32'h002081B3});
    exp_q.push_back({8'h00, 32'h402081B3});
    check_writes("wrap");
    @(posedge clk); #1;

    // Zero-length program: done three cycles after start, nothing written
    start_prog(8'h40, 8'd0);
    wait_done(n);
    chk("len0_latency", 32'(n), 32'd2);
    check_writes("len0");
    @(posedge clk); #1;
    chk("len0_done_pulse", 32'(done), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);

    // Asynchronous reset with a full buffer
    bus.imem_ready = 1'b0;
    start_prog(8'h50, 8'd4);
    send(ENC_ADD, 5'd1, 5'd2, 5'd3, 13'h0000);
    send(ENC_SUB, 5'd1, 5'd2, 5'd3, 13'h0000);
    chk("abort_full", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_imem_we", 32'(bus.imem_we), 32'd0);
    chk("abort_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("abort_imem_wdata", bus.imem_wdata, 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    bus.imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    check_writes("abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
